// File: rtl/adc_result_fifo.sv
// Show-ahead result FIFO behind the SAR conversion core: captures strobed results,
// serves them over valid/ready, and tracks overflow, dropped samples and fill-level IRQ.
module adc_result_fifo #(
    parameter int DATA_BITS     = 12,
    parameter int DEPTH_LOG2    = 4,
    parameter int DROP_CNT_BITS = 8
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [DATA_BITS-1:0]     result_in,
    input  logic                     result_strobe_in,
    input  logic                     rd_ready_in,
    output logic                     rd_valid_out,
    output logic [DATA_BITS-1:0]     rd_data_out,
    output logic [DEPTH_LOG2:0]      fill_level_out,
    output logic                     overflow_out,
    output logic [DROP_CNT_BITS-1:0] dropped_count_out,
    input  logic                     clear_overflow_in,
    input  logic                     flush_in,
    input  logic [DEPTH_LOG2:0]      threshold_in,
    output logic                     threshold_irq_out
);

    localparam int DEPTH = 1 << DEPTH_LOG2;
    localparam int PW    = DEPTH_LOG2 + 1;

    logic [DATA_BITS-1:0]     mem_q [DEPTH];
    logic [PW-1:0]            wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]            rd_ptr_q, rd_ptr_d;
    logic                     overflow_q, overflow_d;
    logic [DROP_CNT_BITS-1:0] drop_cnt_q, drop_cnt_d;
    logic                     irq_q, irq_d;

    logic          empty, full, push, pop, do_write, drop;
    logic [PW-1:0] fill;

    assign empty = (wr_ptr_q == rd_ptr_q);
    assign full  = (wr_ptr_q[DEPTH_LOG2-1:0] == rd_ptr_q[DEPTH_LOG2-1:0]) &&
                   (wr_ptr_q[DEPTH_LOG2] != rd_ptr_q[DEPTH_LOG2]);
    assign fill  = wr_ptr_q - rd_ptr_q;

    assign push = result_strobe_in;
    assign pop  = ~empty & rd_ready_in;

    // When full, a coincident pop frees the head slot, which is exactly the slot wr_ptr addresses.
    assign do_write = ~flush_in & push & (~full | pop);
    assign drop     = ~flush_in & push & full & ~pop;

    always_comb begin
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        overflow_d = overflow_q;
        drop_cnt_d = drop_cnt_q;

        if (flush_in) begin
            wr_ptr_d = rd_ptr_q;
        end else begin
            if (do_write) wr_ptr_d = wr_ptr_q + PW'(1);
            if (pop)      rd_ptr_d = rd_ptr_q + PW'(1);
        end

        // A drop in the same cycle as a clear restarts the count at one.
        if (drop) begin
            overflow_d = 1'b1;
            if (clear_overflow_in)
                drop_cnt_d = DROP_CNT_BITS'(1);
            else if (!(&drop_cnt_q))
                drop_cnt_d = drop_cnt_q + DROP_CNT_BITS'(1);
        end else if (clear_overflow_in) begin
            overflow_d = 1'b0;
            drop_cnt_d = '0;
        end

        irq_d = (threshold_in != '0) && (fill >= threshold_in);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            overflow_q <= 1'b0;
            drop_cnt_q <= '0;
            irq_q      <= 1'b0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            overflow_q <= overflow_d;
            drop_cnt_q <= drop_cnt_d;
            irq_q      <= irq_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_write) mem_q[wr_ptr_q[DEPTH_LOG2-1:0]] <= result_in;
    end

    assign rd_valid_out      = ~empty;
    assign rd_data_out       = mem_q[rd_ptr_q[DEPTH_LOG2-1:0]];
    assign fill_level_out    = fill;
    assign overflow_out      = overflow_q;
    assign dropped_count_out = drop_cnt_q;
    assign threshold_irq_out = irq_q;

endmodule

// File: tb/tb_adc_result_fifo.sv
// Directed testbench for adc_result_fifo: ordering, overflow/drop counting,
// full push+pop, saturation, threshold IRQ, flush and asynchronous reset.
module tb_adc_result_fifo;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [11:0] result_in;
    logic        result_strobe_in;
    logic        rd_ready_in;
    logic        rd_valid_out;
    logic [11:0] rd_data_out;
    logic [4:0]  fill_level_out;
    logic        overflow_out;
    logic [7:0]  dropped_count_out;
    logic        clear_overflow_in;
    logic        flush_in;
    logic [4:0]  threshold_in;
    logic        threshold_irq_out;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    adc_result_fifo #(.DATA_BITS(12), .DEPTH_LOG2(4), .DROP_CNT_BITS(8)) dut (
        .clk               (clk),
        .rst_n             (rst_n),
        .result_in         (result_in),
        .result_strobe_in  (result_strobe_in),
        .rd_ready_in       (rd_ready_in),
        .rd_valid_out      (rd_valid_out),
        .rd_data_out       (rd_data_out),
        .fill_level_out    (fill_level_out),
        .overflow_out      (overflow_out),
        .dropped_count_out (dropped_count_out),
        .clear_overflow_in (clear_overflow_in),
        .flush_in          (flush_in),
        .threshold_in      (threshold_in),
        .threshold_irq_out (threshold_irq_out)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push_words(input int n, input logic [11:0] base);
        for (int i = 0; i < n; i++) begin
            result_in        = base + 12'(i);
            result_strobe_in = 1'b1;
            step();
        end
        result_strobe_in = 1'b0;
    endtask

    task automatic do_flush();
        flush_in = 1'b1;
        step();
        flush_in = 1'b0;
    endtask

    task automatic do_clear();
        clear_overflow_in = 1'b1;
        step();
        clear_overflow_in = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        result_in = '0; result_strobe_in = 1'b0; rd_ready_in = 1'b0;
        clear_overflow_in = 1'b0; flush_in = 1'b0; threshold_in = '0;
        step(); step();
        rst_n = 1'b1;
        step();
        n_checks++;
        if (rd_valid_out !== 1'b0 || fill_level_out !== 5'd0 || overflow_out !== 1'b0 ||
            dropped_count_out !== 8'd0 || threshold_irq_out !== 1'b0) begin
            $display("FAIL reset: valid=%b fill=%0d ovf=%b cnt=%0d irq=%b, required all 0",
                     rd_valid_out, fill_level_out, overflow_out, dropped_count_out, threshold_irq_out);
            n_fail++;
        end
    endtask

    task automatic test_basic();
        logic [11:0] exp_data [3];
        exp_data[0] = 12'h001; exp_data[1] = 12'h7FF; exp_data[2] = 12'hABC;
        for (int i = 0; i < 3; i++) begin
            result_in = exp_data[i]; result_strobe_in = 1'b1;
            step();
            if (i == 0) begin
                n_checks++;
                if (rd_valid_out !== 1'b1 || rd_data_out !== 12'h001) begin
                    $display("FAIL basic_latency: valid=%b data=%h, required 1/001", rd_valid_out, rd_data_out);
                    n_fail++;
                end
            end
        end
        result_strobe_in = 1'b0;
        n_checks++;
        if (fill_level_out !== 5'd3 || rd_valid_out !== 1'b1 || rd_data_out !== 12'h001) begin
            $display("FAIL basic_fill: fill=%0d valid=%b data=%h, required 3/1/001",
                     fill_level_out, rd_valid_out, rd_data_out);
            n_fail++;
        end
        rd_ready_in = 1'b1;
        for (int i = 0; i < 3; i++) begin
            n_checks++;
            if (rd_data_out !== exp_data[i] || rd_valid_out !== 1'b1) begin
                $display("FAIL basic_read%0d: data=%h valid=%b, required %h/1", i, rd_data_out, rd_valid_out, exp_data[i]);
                n_fail++;
            end
            step();
        end
        rd_ready_in = 1'b0;
        n_checks++;
        if (rd_valid_out !== 1'b0 || fill_level_out !== 5'd0) begin
            $display("FAIL basic_empty: valid=%b fill=%0d, required 0/0", rd_valid_out, fill_level_out);
            n_fail++;
        end
    endtask

    task automatic test_overflow();
        push_words(16, 12'h000);
        push_words(3, 12'hFF0);
        n_checks++;
        if (fill_level_out !== 5'd16 || overflow_out !== 1'b1 || dropped_count_out !== 8'd3) begin
            $display("FAIL ovf_flags: fill=%0d ovf=%b cnt=%0d, required 16/1/3",
                     fill_level_out, overflow_out, dropped_count_out);
            n_fail++;
        end
        rd_ready_in = 1'b1;
        for (int i = 0; i < 16; i++) begin
            n_checks++;
            if (rd_data_out !== 12'(i) || rd_valid_out !== 1'b1) begin
                $display("FAIL ovf_drain%0d: data=%h valid=%b, required %h/1", i, rd_data_out, rd_valid_out, 12'(i));
                n_fail++;
            end
            step();
        end
        rd_ready_in = 1'b0;
        n_checks++;
        if (rd_valid_out !== 1'b0) begin
            $display("FAIL ovf_empty: valid=%b, required 0", rd_valid_out);
            n_fail++;
        end
        do_clear();
        n_checks++;
        if (overflow_out !== 1'b0 || dropped_count_out !== 8'd0) begin
            $display("FAIL ovf_clear: ovf=%b cnt=%0d, required 0/0", overflow_out, dropped_count_out);
            n_fail++;
        end
    endtask

    task automatic test_full_push_pop();
        push_words(16, 12'h100);
        result_in = 12'h555; result_strobe_in = 1'b1; rd_ready_in = 1'b1;
        step();
        result_strobe_in = 1'b0; rd_ready_in = 1'b0;
        n_checks++;
        if (overflow_out !== 1'b0 || fill_level_out !== 5'd16 || dropped_count_out !== 8'd0) begin
            $display("FAIL full_pp: ovf=%b fill=%0d cnt=%0d, required 0/16/0",
                     overflow_out, fill_level_out, dropped_count_out);
            n_fail++;
        end
        rd_ready_in = 1'b1;
        for (int i = 0; i < 16; i++) begin
            logic [11:0] exp;
            exp = (i == 15) ? 12'h555 : 12'h101 + 12'(i);
            n_checks++;
            if (rd_data_out !== exp) begin
                $display("FAIL full_pp_read%0d: data=%h, required %h", i, rd_data_out, exp);
                n_fail++;
            end
            step();
        end
        rd_ready_in = 1'b0;
        n_checks++;
        if (rd_valid_out !== 1'b0) begin
            $display("FAIL full_pp_empty: valid=%b, required 0", rd_valid_out);
            n_fail++;
        end
    endtask

    task automatic test_saturate();
        push_words(16, 12'h200);
        push_words(300, 12'h300);
        n_checks++;
        if (dropped_count_out !== 8'd255 || overflow_out !== 1'b1 || fill_level_out !== 5'd16) begin
            $display("FAIL sat_count: cnt=%0d ovf=%b fill=%0d, required 255/1/16",
                     dropped_count_out, overflow_out, fill_level_out);
            n_fail++;
        end
        clear_overflow_in = 1'b1; result_strobe_in = 1'b1;
        step();
        clear_overflow_in = 1'b0; result_strobe_in = 1'b0;
        n_checks++;
        if (overflow_out !== 1'b1 || dropped_count_out !== 8'd1) begin
            $display("FAIL sat_clear_drop: ovf=%b cnt=%0d, required 1/1", overflow_out, dropped_count_out);
            n_fail++;
        end
        n_checks++;
        if (rd_data_out !== 12'h200) begin
            $display("FAIL sat_head: data=%h, required 200", rd_data_out);
            n_fail++;
        end
        do_flush();
        n_checks++;
        if (fill_level_out !== 5'd0 || overflow_out !== 1'b1 || dropped_count_out !== 8'd1) begin
            $display("FAIL sat_flush: fill=%0d ovf=%b cnt=%0d, required 0/1/1",
                     fill_level_out, overflow_out, dropped_count_out);
            n_fail++;
        end
        do_clear();
    endtask

    task automatic test_threshold();
        threshold_in = 5'd4;
        push_words(4, 12'h010);
        n_checks++;
        if (fill_level_out !== 5'd4 || threshold_irq_out !== 1'b0) begin
            $display("FAIL irq_lag_rise: fill=%0d irq=%b, required 4/0", fill_level_out, threshold_irq_out);
            n_fail++;
        end
        step();
        n_checks++;
        if (threshold_irq_out !== 1'b1) begin
            $display("FAIL irq_rise: irq=%b, required 1", threshold_irq_out);
            n_fail++;
        end
        rd_ready_in = 1'b1;
        step();
        rd_ready_in = 1'b0;
        n_checks++;
        if (fill_level_out !== 5'd3 || threshold_irq_out !== 1'b1) begin
            $display("FAIL irq_lag_fall: fill=%0d irq=%b, required 3/1", fill_level_out, threshold_irq_out);
            n_fail++;
        end
        step();
        n_checks++;
        if (threshold_irq_out !== 1'b0) begin
            $display("FAIL irq_fall: irq=%b, required 0", threshold_irq_out);
            n_fail++;
        end
        do_flush();
        threshold_in = 5'd0;
        push_words(16, 12'h020);
        step();
        n_checks++;
        if (fill_level_out !== 5'd16 || threshold_irq_out !== 1'b0) begin
            $display("FAIL irq_disabled: fill=%0d irq=%b, required 16/0", fill_level_out, threshold_irq_out);
            n_fail++;
        end
        threshold_in = 5'd17;
        step(); step();
        n_checks++;
        if (threshold_irq_out !== 1'b0) begin
            $display("FAIL irq_above_depth: irq=%b, required 0", threshold_irq_out);
            n_fail++;
        end
        threshold_in = 5'd16;
        step();
        n_checks++;
        if (threshold_irq_out !== 1'b1) begin
            $display("FAIL irq_at_depth: irq=%b, required 1", threshold_irq_out);
            n_fail++;
        end
        threshold_in = 5'd0;
        do_flush();
    endtask

    task automatic test_flush();
        push_words(10, 12'h040);
        n_checks++;
        if (fill_level_out !== 5'd10) begin
            $display("FAIL flush_prefill: fill=%0d, required 10", fill_level_out);
            n_fail++;
        end
        flush_in = 1'b1; result_strobe_in = 1'b1; result_in = 12'hEEE;
        step();
        flush_in = 1'b0; result_strobe_in = 1'b0;
        n_checks++;
        if (fill_level_out !== 5'd0 || rd_valid_out !== 1'b0 ||
            overflow_out !== 1'b0 || dropped_count_out !== 8'd0) begin
            $display("FAIL flush: fill=%0d valid=%b ovf=%b cnt=%0d, required 0/0/0/0",
                     fill_level_out, rd_valid_out, overflow_out, dropped_count_out);
            n_fail++;
        end
        push_words(1, 12'h3C3);
        n_checks++;
        if (rd_valid_out !== 1'b1 || rd_data_out !== 12'h3C3 || fill_level_out !== 5'd1) begin
            $display("FAIL flush_reuse: valid=%b data=%h fill=%0d, required 1/3C3/1",
                     rd_valid_out, rd_data_out, fill_level_out);
            n_fail++;
        end
    endtask

    task automatic test_async_reset();
        threshold_in = 5'd2;
        push_words(17, 12'h080);
        step();
        n_checks++;
        if (overflow_out !== 1'b1 || threshold_irq_out !== 1'b1 || fill_level_out !== 5'd16) begin
            $display("FAIL areset_pre: ovf=%b irq=%b fill=%0d, required 1/1/16",
                     overflow_out, threshold_irq_out, fill_level_out);
            n_fail++;
        end
        #2;
        rst_n = 1'b0;
        #1;
        n_checks++;
        if (rd_valid_out !== 1'b0 || fill_level_out !== 5'd0 || overflow_out !== 1'b0 ||
            dropped_count_out !== 8'd0 || threshold_irq_out !== 1'b0) begin
            $display("FAIL areset: valid=%b fill=%0d ovf=%b cnt=%0d irq=%b, required all 0",
                     rd_valid_out, fill_level_out, overflow_out, dropped_count_out, threshold_irq_out);
            n_fail++;
        end
        step();
        rst_n = 1'b1;
        threshold_in = 5'd0;
        step();
    endtask

    initial begin
        test_reset();
        test_basic();
        test_overflow();
        test_full_push_pop();
        test_saturate();
        test_threshold();
        test_flush();
        test_async_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/adc_result_fifo.md
Name: adc_result_fifo

Overview:
- Downstream buffer for the SAR conversion core. Captures each 12-bit conversion result on the core's one-cycle conversion-finished strobe.
- Stores results in a small show-ahead FIFO and presents them to the host/bus side over a valid/ready handshake.
- Flags overflow, counts dropped samples and raises a fill-level threshold interrupt, so the bus can service the ADC in bursts without losing track of data loss.

Parameters:
DATA_BITS, 12, result word width; equals the conversion core's MATRIX_BITS
DEPTH_LOG2, 4, log2 of FIFO depth (default depth 16)
DROP_CNT_BITS, 8, width of the saturating dropped-sample counter

Ports:
clk  input  1  system clock; all state updates on rising edge
rst_n  input  1  asynchronous active-low reset
result_in  input  DATA_BITS  conversion result; valid only in cycles where result_strobe_in=1
result_strobe_in  input  1  one-cycle pulse per finished conversion; every high cycle is one push request
rd_ready_in  input  1  consumer accepts head word this cycle
rd_valid_out  output  1  FIFO not empty; rd_data_out is valid
rd_data_out  output  DATA_BITS  head-of-FIFO word (show-ahead)
fill_level_out  output  DEPTH_LOG2+1  number of stored words, 0..2**DEPTH_LOG2
overflow_out  output  1  sticky: at least one result dropped since last clear
dropped_count_out  output  DROP_CNT_BITS  saturating count of dropped results
clear_overflow_in  input  1  synchronous clear of overflow_out and dropped_count_out
flush_in  input  1  synchronous discard of all stored words
threshold_in  input  DEPTH_LOG2+1  interrupt fill threshold; 0 disables the interrupt
threshold_irq_out  output  1  registered; high while fill_level >= threshold_in and threshold_in != 0

Behaviour:
- Reset (rst_n=0, asynchronous): write and read pointers = 0, fill level = 0, overflow_out=0, dropped_count_out=0, threshold_irq_out=0. Hence rd_valid_out=0.
- rd_data_out is don't-care while rd_valid_out=0. Memory contents are not reset.
- Storage: 2**DEPTH_LOG2 registers of DATA_BITS. Pointers are DEPTH_LOG2+1 bits; the extra MSB distinguishes full from empty.
  - empty = (wr_ptr == rd_ptr)
  - full = low bits equal AND MSBs differ
  - Pointers wrap modulo 2**(DEPTH_LOG2+1).
- Push = result_strobe_in. Pop = rd_valid_out & rd_ready_in.
- Latency: a push in cycle N, into an empty FIFO, gives rd_valid_out=1 and rd_data_out=result_in(N) in cycle N+1.
- Normal push (not full): mem[wr_ptr] <= result_in; wr_ptr increments.
- Pop: rd_ptr increments. rd_ready_in while empty has no effect.
- Simultaneous push and pop:
  - When not full: both happen; fill level unchanged.
  - When full: both happen; the freed slot takes the new word; no overflow.
  - When empty: only the push happens.
- Push when full without pop: the new word is dropped and the stored data is unchanged. overflow_out <= 1; dropped_count_out increments and saturates at all-ones.
- clear_overflow_in: overflow_out <= 0 and dropped_count_out <= 0. If a drop occurs in the same cycle, the drop wins: overflow_out=1, dropped_count_out=1.
- flush_in: wr_ptr <= rd_ptr and fill level becomes 0.
  - Takes priority over push and pop in the same cycle; that cycle's strobe is discarded and is not counted as a drop.
  - Does not affect overflow_out or dropped_count_out.
- fill_level_out = wr_ptr - rd_ptr (combinational from pointers).
- threshold_irq_out: registered each cycle from the current fill level, so it lags fill_level_out by one cycle. It is level-sensitive, not sticky.
- No data path depends on threshold_in except the IRQ compare. threshold_in above the depth never fires.

Test Plan:
- Reset then push 3 results 0x001, 0x7FF, 0xABC, rd_ready_in=0 -> fill_level_out=3, rd_valid_out=1, rd_data_out=0x001. Hold ready 3 cycles -> data 0x001, 0x7FF, 0xABC in order, then rd_valid_out=0, fill=0.
- Push 16 results 0..15 with ready low, then 3 more strobes -> fill=16, first 16 preserved, overflow_out=1, dropped_count_out=3. Drain reads 0..15. Pulse clear_overflow_in -> overflow_out=0, count=0.
- Full FIFO with strobe and rd_ready_in in the same cycle, data 0x555 -> no overflow, fill stays 16. The 16th read after that cycle returns 0x555.
- 300 strobes into a full FIFO -> dropped_count_out saturates at 255. clear_overflow_in coincident with a drop -> overflow_out=1, count=1.
- threshold_in=4: push 4 -> IRQ rises one cycle after fill reaches 4. Pop 1 -> IRQ falls one cycle after fill=3. threshold_in=0 with fill 16 -> IRQ stays 0.
- Fill 10 words, assert flush_in with a coincident strobe -> next cycle fill=0, rd_valid_out=0, no drop counted. Assert rst_n low mid-stream -> all outputs 0 immediately, without waiting for a clock edge.
